// File: rtl/intersection_scheduler.sv
// intersection_scheduler
// Decides which vehicle direction (north-south or east-west) owns the
// junction, and inserts a pedestrian walk phase when a request is pending.
// It is a Moore machine with one phase counter. Every phase lasts exactly its
// programmed number of clocks.
//
// Ports:
//   clk                            rising-edge clock
//   rst                            synchronous active-high reset
//   ped_req                        pedestrian button, a one-cycle pulse is enough
//   ns_red/ns_yellow/ns_green      north-south lamps, one-hot
//   ew_red/ew_yellow/ew_green      east-west lamps, one-hot
//   walk                           pedestrian walk lamp
//   ped_wait                       a request is latched and not yet served
module intersection_scheduler #(
    parameter int GREEN_CYCLES  = 5,
    parameter int YELLOW_CYCLES = 2,
    parameter int ALLRED_CYCLES = 1,
    parameter int WALK_CYCLES   = 4,
    parameter int CNT_W         = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic ped_req,
    output logic ns_red,
    output logic ns_yellow,
    output logic ns_green,
    output logic ew_red,
    output logic ew_yellow,
    output logic ew_green,
    output logic walk,
    output logic ped_wait
);

    typedef enum logic [2:0] {
        NS_G  = 3'd0,
        NS_Y  = 3'd1,
        AR_NS = 3'd2,
        EW_G  = 3'd3,
        EW_Y  = 3'd4,
        AR_EW = 3'd5,
        WALK  = 3'd6
    } state_t;

    // Last count value of each phase. These are held as DUR-1 so that a
    // duration of exactly 2^CNT_W still fits in the counter.
    localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_CYCLES - 1);
    localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_CYCLES - 1);
    localparam logic [CNT_W-1:0] WALK_LAST   = CNT_W'(WALK_CYCLES - 1);

    state_t           state_r;
    state_t           state_next_s;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] last_s;
    logic             phase_done_s;
    logic             ped_pending_r;
    logic             enter_walk_s;
    logic             next_dir_r;      // 1'b0: NS after walk, 1'b1: EW after walk
    logic             next_dir_next_s;
    logic [6:0]       lamps_r;

    // Lamp pattern of a state: {ns_r, ns_y, ns_g, ew_r, ew_y, ew_g, walk}.
    function automatic logic [6:0] decode_lamps(input state_t s);
        case (s)
            NS_G:    decode_lamps = 7'b001_100_0;
            NS_Y:    decode_lamps = 7'b010_100_0;
            EW_G:    decode_lamps = 7'b100_001_0;
            EW_Y:    decode_lamps = 7'b100_010_0;
            WALK:    decode_lamps = 7'b100_100_1;
            default: decode_lamps = 7'b100_100_0;
        endcase
    endfunction

    // Phase length lookup and end-of-phase detection.
    always_comb begin
        case (state_r)
            NS_G, EW_G:   last_s = GREEN_LAST;
            NS_Y, EW_Y:   last_s = YELLOW_LAST;
            AR_NS, AR_EW: last_s = ALLRED_LAST;
            WALK:         last_s = WALK_LAST;
            default:      last_s = ALLRED_LAST;
        endcase
        phase_done_s = (count_r == last_s);
    end

    // Next-state selection. The walk decision uses only the registered request.
    always_comb begin
        state_next_s    = state_r;
        next_dir_next_s = next_dir_r;
        if (phase_done_s) begin
            case (state_r)
                NS_G:    state_next_s = NS_Y;
                NS_Y:    state_next_s = AR_NS;
                EW_G:    state_next_s = EW_Y;
                EW_Y:    state_next_s = AR_EW;
                AR_NS: begin
                    if (ped_pending_r) begin
                        state_next_s    = WALK;
                        next_dir_next_s = 1'b1;
                    end else begin
                        state_next_s = EW_G;
                    end
                end
                AR_EW: begin
                    if (ped_pending_r) begin
                        state_next_s    = WALK;
                        next_dir_next_s = 1'b0;
                    end else begin
                        state_next_s = NS_G;
                    end
                end
                WALK:    state_next_s = next_dir_r ? EW_G : NS_G;
                default: state_next_s = AR_EW;
            endcase
        end else begin
            state_next_s = state_r;
        end
        enter_walk_s = (state_next_s == WALK) && (state_r != WALK);
    end

    // Sequencer state, phase counter, request latch and registered lamps.
    // The lamps register the decode of the next state, so they always match
    // the state register without any combinational path from the inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= AR_EW;
            count_r       <= '0;
            ped_pending_r <= 1'b0;
            next_dir_r    <= 1'b0;
            lamps_r       <= decode_lamps(AR_EW);
        end else begin
            state_r    <= state_next_s;
            count_r    <= phase_done_s ? '0 : count_r + CNT_W'(1);
            next_dir_r <= next_dir_next_s;
            lamps_r    <= decode_lamps(state_next_s);
            // Entering walk serves the request, so the clear wins over a
            // press on the same edge.
            if (enter_walk_s) begin
                ped_pending_r <= 1'b0;
            end else begin
                ped_pending_r <= ped_pending_r | (ped_req && (state_r != WALK));
            end
        end
    end

    assign {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk} = lamps_r;
    assign ped_wait = ped_pending_r;

endmodule

// File: tb/tb_intersection_scheduler.sv
// Bench for intersection_scheduler. It runs a default-parameter instance and
// a short-phase instance (G=1, Y=1, AR=2, W=1) from the same stimulus. Both
// are compared every cycle against a countdown-based phase model.
module tb_intersection_scheduler;

    logic clk = 1'b0;
    logic rst;
    logic ped_req;
    wire [6:0] l0;
    wire [6:0] l1;
    wire       pw0;
    wire       pw1;

    int n_checks = 0;
    int n_fail   = 0;

    // Model phase ids: 0 NS_G, 1 NS_Y, 2 AR_NS, 3 EW_G, 4 EW_Y, 5 AR_EW, 6 WALK.
    int m_ph[2];
    int m_left[2];     // clocks remaining in the current phase, including this one
    int m_pend[2];
    int m_after[2];    // phase that follows the walk

    always #5 clk = ~clk;

    intersection_scheduler dut0 (
        .clk(clk), .rst(rst), .ped_req(ped_req),
        .ns_red(l0[6]), .ns_yellow(l0[5]), .ns_green(l0[4]),
        .ew_red(l0[3]), .ew_yellow(l0[2]), .ew_green(l0[1]),
        .walk(l0[0]), .ped_wait(pw0)
    );

    intersection_scheduler #(
        .GREEN_CYCLES(1), .YELLOW_CYCLES(1), .ALLRED_CYCLES(2),
        .WALK_CYCLES(1), .CNT_W(2)
    ) dut1 (
        .clk(clk), .rst(rst), .ped_req(ped_req),
        .ns_red(l1[6]), .ns_yellow(l1[5]), .ns_green(l1[4]),
        .ew_red(l1[3]), .ew_yellow(l1[2]), .ew_green(l1[1]),
        .walk(l1[0]), .ped_wait(pw1)
    );

    function automatic int dur(input int inst, input int ph);
        if (inst == 0) begin
            case (ph)
                0, 3:    dur = 5;
                1, 4:    dur = 2;
                2, 5:    dur = 1;
                default: dur = 4;
            endcase
        end else begin
            case (ph)
                2, 5:    dur = 2;
                default: dur = 1;
            endcase
        end
    endfunction

    function automatic int exp_lamps(input int ph);
        exp_lamps = 0;
        if (!(ph == 0 || ph == 1)) exp_lamps += 64;
        if (ph == 1) exp_lamps += 32;
        if (ph == 0) exp_lamps += 16;
        if (!(ph == 3 || ph == 4)) exp_lamps += 8;
        if (ph == 4) exp_lamps += 4;
        if (ph == 3) exp_lamps += 2;
        if (ph == 6) exp_lamps += 1;
    endfunction

    task automatic model_edge(input int i, input logic r, input logic p);
        int np;
        int nx;
        if (r) begin
            m_ph[i] = 5; m_left[i] = dur(i, 5); m_pend[i] = 0; m_after[i] = 0;
        end else begin
            np = (m_pend[i] != 0 || (p && m_ph[i] != 6)) ? 1 : 0;
            if (m_left[i] == 1) begin
                case (m_ph[i])
                    0: nx = 1;
                    1: nx = 2;
                    3: nx = 4;
                    4: nx = 5;
                    2: begin
                        if (m_pend[i] != 0) begin nx = 6; m_after[i] = 3; end
                        else nx = 3;
                    end
                    5: begin
                        if (m_pend[i] != 0) begin nx = 6; m_after[i] = 0; end
                        else nx = 0;
                    end
                    default: nx = m_after[i];
                endcase
                if (nx == 6) np = 0;
                m_ph[i] = nx;
                m_left[i] = dur(i, nx);
            end else begin
                m_left[i] = m_left[i] - 1;
            end
            m_pend[i] = np;
        end
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("lamps0", int'(l0), exp_lamps(m_ph[0]));
        chk("ped_wait0", int'(pw0), m_pend[0]);
        chk("count0", int'(dut0.count_r), dur(0, m_ph[0]) - m_left[0]);
        chk("lamps1", int'(l1), exp_lamps(m_ph[1]));
        chk("ped_wait1", int'(pw1), m_pend[1]);
        chk("count1", int'(dut1.count_r), dur(1, m_ph[1]) - m_left[1]);
        chk("green_excl0", int'(l0[4] & l0[1]), 0);
        chk("ns_onehot0", int'(l0[6]) + int'(l0[5]) + int'(l0[4]), 1);
        chk("ew_onehot0", int'(l0[3]) + int'(l0[2]) + int'(l0[1]), 1);
        chk("walk_reds0", int'(l0[0] & !(l0[6] & l0[3])), 0);
        chk("green_excl1", int'(l1[4] & l1[1]), 0);
        chk("walk_reds1", int'(l1[0] & !(l1[6] & l1[3])), 0);
    endtask

    task automatic step(input logic r, input logic p);
        rst = r;
        ped_req = p;
        @(posedge clk);
        model_edge(0, r, p);
        model_edge(1, r, p);
        @(negedge clk);
        check_all();
    endtask

    // Advance (bounded) until the default-instance model is in phase ph with
    // 'left' clocks remaining.
    task automatic run_until(input string tag, input int ph, input int left);
        bit found = 1'b0;
        for (int k = 0; k < 64 && !found; k++) begin
            if (m_ph[0] == ph && m_left[0] == left) found = 1'b1;
            else step(1'b0, 1'b0);
        end
        n_checks++;
        assert (found) else begin
            n_fail++;
            $error("FAIL %s observed=timeout expected=phase %0d left %0d", tag, ph, left);
        end
    endtask

    initial begin
        rst = 1'b1;
        ped_req = 1'b0;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        // Free running with no requests: two full periods.
        for (int k = 0; k < 32; k++) step(1'b0, 1'b0);
        // Press in the second NS green cycle.
        run_until("ns_g_2nd", 0, 4);
        step(1'b0, 1'b1);
        // Press on the edge entering walk, then during walk.
        run_until("ar_ns_last", 2, 1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        for (int k = 0; k < 20; k++) step(1'b0, 1'b0);
        // Press in the single AR_EW cycle: served after AR_NS.
        run_until("ar_ew_last", 5, 1);
        step(1'b0, 1'b1);
        // Reset in the third walk cycle.
        run_until("walk_3rd", 6, 2);
        step(1'b1, 1'b0);
        for (int k = 0; k < 20; k++) step(1'b0, 1'b0);
        // Random presses with occasional resets.
        for (int k = 0; k < 600; k++) begin
            step(($urandom % 150) == 0, ($urandom % 9) == 0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
